// File: rtl/mem_regfile_mc_pkg.sv
// Purpose: shared types and helpers for the mem_regfile_mc register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_regfile_mc_pkg;

    typedef enum logic [1:0] {
        RW  = 2'd0,
        RO  = 2'd1,
        W1C = 2'd2
    } reg_mode_e;

    // Upper bounds for the helper functions. Callers size-cast in and out.
    localparam int MAX_DW   = 1024;
    localparam int MAX_NB   = MAX_DW / 8;
    localparam int MAX_REGS = 4096;

    // Returned for reads of unmapped addresses when decode checking is built in.
    localparam logic [31:0] DECODE_ERR_WORD = 32'hDEC0_DEE0;

    // Expand byte write enables into a bit mask.
    function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_NB-1:0] we);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_NB; b++) begin
            m[b*8 +: 8] = {8{we[b]}};
        end
        return m;
    endfunction

    // RO takes priority; overlap is rejected at elaboration by the top.
    function automatic reg_mode_e reg_mode(input int i,
                                           input logic [MAX_REGS-1:0] ro_mask,
                                           input logic [MAX_REGS-1:0] w1c_mask);
        if (ro_mask[i])  return RO;
        if (w1c_mask[i]) return W1C;
        return RW;
    endfunction

endpackage

// File: rtl/mem_regfile_mc_rdpipe.sv
// Purpose: read-data mux (error word / RO source / register) feeding a RD_LAT-deep data+valid pipe.
// Latency: RD_LAT cycles from read request to rd_valid; data stages load only on valid, so rd_data holds.
// Backpressure: none; one result per cycle, in request order.
// Ports: clk, resetn | rd_req, rd_err, idx | regs, read_val (NREGS x DW) | rd_data, rd_valid.
module mem_regfile_mc_rdpipe
    import mem_regfile_mc_pkg::*;
#(
    parameter int                             NADDR    = 4,
    parameter int                             DW       = 32,
    parameter int                             RD_LAT   = 1,
    parameter logic [(2**NADDR)-1:0]          RO_MASK  = '0,
    parameter logic [DW-1:0]                  ERR_WORD = '0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              rd_req,
    input  logic                              rd_err,
    input  logic [NADDR-1:0]                  idx,
    input  logic [(2**NADDR)-1:0][DW-1:0]     regs,
    input  logic [(2**NADDR)-1:0][DW-1:0]     read_val,
    output logic [DW-1:0]                     rd_data,
    output logic                              rd_valid
);

    logic [DW-1:0] src_dat;
    logic [DW-1:0] s1_dat;
    logic          s1_vld;

    assign src_dat = rd_err       ? ERR_WORD      :
                     RO_MASK[idx] ? read_val[idx] : regs[idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_req;
            if (rd_req) s1_dat <= src_dat;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] s2_dat;
        logic          s2_vld;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s2_dat <= '0;
                s2_vld <= 1'b0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_dat <= s1_dat;
            end
        end

        assign rd_data  = s2_dat;
        assign rd_valid = s2_vld;
    end else begin : g_lat1
        assign rd_data  = s1_dat;
        assign rd_valid = s1_vld;
    end

endmodule

// File: rtl/mem_regfile_mc.sv
// Purpose: parametrised register file on a BRAM-controller style port; per-register RW / RO / W1C modes.
// Latency: writes land at the next edge; reads return after RD_LAT (1 or 2) cycles, strobes pulse 1 cycle.
// Backpressure: none; accepts one access per cycle. Build option: MEM_REGFILE_MC_DECODE_ERR_EN.
// Ports: clk, resetn | en, we[NB], addr, wr_data | rd_data, rd_valid | reg_val, pul_val, wr_stb, rd_stb |
//        read_val (RO sources), sts_set (W1C set bits) | err_cnt (unmapped accesses, saturating).
module mem_regfile_mc
    import mem_regfile_mc_pkg::*;
#(
    parameter int                               NADDR    = 4,
    parameter int                               DW       = 32,
    parameter int                               ADDR_W   = 12,
    parameter int                               RD_LAT   = 1,
    parameter logic [(2**NADDR)-1:0][DW-1:0]    INIT_REG = '0,
    parameter logic [(2**NADDR)-1:0]            RO_MASK  = '0,
    parameter logic [(2**NADDR)-1:0]            W1C_MASK = '0
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                en,
    input  logic [DW/8-1:0]                     we,
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [DW-1:0]                       wr_data,
    output logic [DW-1:0]                       rd_data,
    output logic                                rd_valid,
    output logic [(2**NADDR)-1:0][DW-1:0]       reg_val,
    output logic [(2**NADDR)-1:0][DW-1:0]       pul_val,
    output logic [(2**NADDR)-1:0]               wr_stb,
    output logic [(2**NADDR)-1:0]               rd_stb,
    input  logic [(2**NADDR)-1:0][DW-1:0]       read_val,
    input  logic [(2**NADDR)-1:0][DW-1:0]       sts_set,
    output logic [15:0]                         err_cnt
);

    localparam int            NREGS    = 2**NADDR;
    localparam logic [DW-1:0] ERR_WORD = DW'({(DW/32 + 1){DECODE_ERR_WORD}});

    if ((RO_MASK & W1C_MASK) != '0) begin : g_mask_overlap
        $error("mem_regfile_mc: RO_MASK and W1C_MASK overlap");
    end
    if ((DW % 8) != 0) begin : g_dw_check
        $error("mem_regfile_mc: DW must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_check
        $error("mem_regfile_mc: RD_LAT must be 1 or 2");
    end

    logic [NADDR-1:0]              idx;
    logic                          wr_req;
    logic                          rd_req;
    logic                          unmapped;
    logic                          wr_hit;
    logic                          rd_hit;
    logic [DW-1:0]                 wr_mask;
    logic [DW-1:0]                 wr_bits;
    logic [NREGS-1:0][DW-1:0]      regs_nxt;
    logic [DW-1:0]                 sel;
    logic                          unused_bits;

    assign idx     = addr[NADDR+1:2];
    assign wr_req  = en && (|we);
    assign rd_req  = en && (we == '0);
    assign wr_mask = DW'(lane_mask(MAX_NB'(we)));
    assign wr_bits = wr_data & wr_mask;

    // Byte offset bits never take part in decode.
    assign unused_bits = ^{addr[1:0], addr[ADDR_W-1:NADDR+2], sts_set};

`ifdef MEM_REGFILE_MC_DECODE_ERR_EN
    assign unmapped = |addr[ADDR_W-1:NADDR+2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt <= '0;
        end else if (en && unmapped && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    // Upper address bits alias onto the mapped window.
    assign unmapped = 1'b0;
    assign err_cnt  = '0;
`endif

    assign wr_hit = wr_req && !unmapped;
    assign rd_hit = rd_req && !unmapped;

    // W1C regs update every cycle so sts_set is never lost; set wins over clear.
    always_comb begin
        regs_nxt = reg_val;
        sel      = '0;
        for (int i = 0; i < NREGS; i++) begin
            sel = (wr_hit && (idx == NADDR'(i))) ? wr_mask : '0;
            case (reg_mode(i, MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK)))
                RW:      regs_nxt[i] = (reg_val[i] & ~sel) | (wr_data & sel);
                W1C:     regs_nxt[i] = (reg_val[i] & ~(wr_data & sel)) | sts_set[i];
                default: regs_nxt[i] = reg_val[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_val <= INIT_REG;
            pul_val <= '0;
            wr_stb  <= '0;
            rd_stb  <= '0;
        end else begin
            reg_val <= regs_nxt;
            pul_val <= '0;
            wr_stb  <= '0;
            rd_stb  <= '0;
            // RO writes are dropped from storage but still signalled to user logic.
            if (wr_hit) begin
                wr_stb[idx]  <= 1'b1;
                pul_val[idx] <= wr_bits;
            end
            if (rd_hit) begin
                rd_stb[idx] <= 1'b1;
            end
        end
    end

    mem_regfile_mc_rdpipe #(
        .NADDR    (NADDR),
        .DW       (DW),
        .RD_LAT   (RD_LAT),
        .RO_MASK  (RO_MASK),
        .ERR_WORD (ERR_WORD)
    ) u_rdpipe (
        .clk      (clk),
        .resetn   (resetn),
        .rd_req   (rd_req),
        .rd_err   (unmapped),
        .idx      (idx),
        .regs     (reg_val),
        .read_val (read_val),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_mem_regfile_mc.sv
// Purpose: directed self-checking bench for mem_regfile_mc, RD_LAT=1 and RD_LAT=2 instances side by side.
// Latency: read results are scoreboarded with the cycle they are due in, so latency is checked too.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_mem_regfile_mc;

    localparam int NADDR = 4;
    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int NB    = 4;

    function automatic logic [NREGS-1:0][DW-1:0] mk_init();
        logic [NREGS-1:0][DW-1:0] r;
        for (int k = 0; k < NREGS; k++) r[k] = k * 32'h1111_1111;
        return r;
    endfunction

    localparam logic [NREGS-1:0][DW-1:0] INIT = mk_init();

    logic                      clk = 1'b0;
    logic                      resetn;
    logic                      en;
    logic [NB-1:0]             we;
    logic [11:0]               addr;
    logic [DW-1:0]             wr_data;
    logic [NREGS-1:0][DW-1:0]  read_val;
    logic [NREGS-1:0][DW-1:0]  sts_set;

    logic [DW-1:0]             rd_data1, rd_data2;
    logic                      rd_valid1, rd_valid2;
    logic [NREGS-1:0][DW-1:0]  reg_val1, reg_val2, pul_val1, pul_val2;
    logic [NREGS-1:0]          wr_stb1, wr_stb2, rd_stb1, rd_stb2;
    logic [15:0]               err_cnt1, err_cnt2;

    always #5 clk = ~clk;

    mem_regfile_mc #(
        .NADDR(NADDR), .DW(DW), .ADDR_W(12), .RD_LAT(1),
        .INIT_REG(INIT), .RO_MASK(16'h0003), .W1C_MASK(16'h0020)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .en(en), .we(we), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .reg_val(reg_val1), .pul_val(pul_val1),
        .wr_stb(wr_stb1), .rd_stb(rd_stb1), .read_val(read_val), .sts_set(sts_set),
        .err_cnt(err_cnt1)
    );

    mem_regfile_mc #(
        .NADDR(NADDR), .DW(DW), .ADDR_W(12), .RD_LAT(2),
        .INIT_REG(INIT), .RO_MASK(16'h0003), .W1C_MASK(16'h0020)
    ) u_dut2 (
        .clk(clk), .resetn(resetn), .en(en), .we(we), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .reg_val(reg_val2), .pul_val(pul_val2),
        .wr_stb(wr_stb2), .rd_stb(rd_stb2), .read_val(read_val), .sts_set(sts_set),
        .err_cnt(err_cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0;
        we = '0;
        step();
    endtask

    task automatic do_write(input logic [11:0] a, input logic [NB-1:0] w, input logic [31:0] d);
        en      = 1'b1;
        we      = w;
        addr    = a;
        wr_data = d;
    endtask

    // Captured at the next edge; visible RD_LAT edges later.
    task automatic do_read(input logic [11:0] a, input logic [31:0] exp);
        exp_t e1, e2;
        en   = 1'b1;
        we   = '0;
        addr = a;
        e1.dat = exp; e1.due = cyc + 1;
        e2.dat = exp; e2.due = cyc + 2;
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    exp_t m1, m2;

    always @(negedge clk) begin
        if (resetn) begin
            if (rd_valid1) begin
                if (q1.size() == 0) chk("rd1_unexpected_valid", 32'(rd_valid1), 32'd0);
                else begin
                    m1 = q1.pop_front();
                    chk("rd1_data", rd_data1, m1.dat);
                    chk("rd1_cycle", cyc, m1.due);
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                chk("rd1_missing_valid", 32'(rd_valid1), 32'd1);
                void'(q1.pop_front());
            end
            if (rd_valid2) begin
                if (q2.size() == 0) chk("rd2_unexpected_valid", 32'(rd_valid2), 32'd0);
                else begin
                    m2 = q2.pop_front();
                    chk("rd2_data", rd_data2, m2.dat);
                    chk("rd2_cycle", cyc, m2.due);
                end
            end else if (q2.size() != 0 && q2[0].due <= cyc) begin
                chk("rd2_missing_valid", 32'(rd_valid2), 32'd1);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        en       = 1'b0;
        we       = '0;
        addr     = '0;
        wr_data  = '0;
        read_val = '0;
        sts_set  = '0;
        repeat (2) step();

        // Reset state
        chk("rst_reg2",     reg_val1[2], 32'h2222_2222);
        chk("rst_reg5",     reg_val1[5], 32'h5555_5555);
        chk("rst_reg5_l2",  reg_val2[5], 32'h5555_5555);
        chk("rst_rd_data1", rd_data1, 32'h0);
        chk("rst_rd_data2", rd_data2, 32'h0);
        chk("rst_rd_vld1",  32'(rd_valid1), 32'h0);
        chk("rst_wr_stb",   32'(wr_stb1), 32'h0);
        chk("rst_rd_stb",   32'(rd_stb1), 32'h0);
        chk("rst_pul2",     pul_val1[2], 32'h0);
        chk("rst_err_cnt",  32'(err_cnt1), 32'h0);
        resetn = 1'b1;
        step();

        // Byte-lane write to RW reg2, then read-after-write
        do_write(12'h008, 4'b0011, 32'hA5A5_A5A5);
        step();
        chk("wr_reg2",     reg_val1[2], 32'h2222_A5A5);
        chk("wr_pul2",     pul_val1[2], 32'h0000_A5A5);
        chk("wr_stb2",     32'(wr_stb1), 32'h0004);
        do_read(12'h008, 32'h2222_A5A5);
        step();
        chk("wr_stb_clr",  32'(wr_stb1), 32'h0);
        chk("pul_clr",     pul_val1[2], 32'h0);
        chk("rd_stb2",     32'(rd_stb1), 32'h0004);
        idle();
        chk("rd_stb_clr",  32'(rd_stb1), 32'h0);

        // RO reg0 reads fabric value; writes dropped but still strobed
        read_val[0] = 32'hDEAD_BEEF;
        read_val[1] = 32'h0123_4567;
        do_read(12'h000, 32'hDEAD_BEEF);
        step();
        chk("ro_rd_stb0",  32'(rd_stb1), 32'h0001);
        do_write(12'h000, 4'b1111, 32'h0000_0001);
        step();
        chk("ro_wr_drop",  reg_val1[0], 32'h0000_0000);
        chk("ro_wr_stb",   32'(wr_stb1), 32'h0001);
        chk("ro_pul",      pul_val1[0], 32'h0000_0001);
        idle();

        // en=0: write-looking inputs have no effect
        en = 1'b0; we = 4'b1111; addr = 12'h008; wr_data = 32'h0;
        step();
        chk("en0_reg2",    reg_val1[2], 32'h2222_A5A5);
        chk("en0_wr_stb",  32'(wr_stb1), 32'h0);
        idle();

        // W1C reg5 sticky set, set-wins collision, then clear
        sts_set[5] = 32'h8;
        step();
        sts_set[5] = 32'h0;
        chk("w1c_set",     reg_val1[5], 32'h5555_555D);
        step();
        chk("w1c_sticky",  reg_val1[5], 32'h5555_555D);
        do_write(12'h014, 4'b1111, 32'h8);
        sts_set[5] = 32'h8;
        step();
        chk("w1c_collide", reg_val1[5], 32'h5555_555D);
        sts_set[5] = 32'h0;
        step();
        chk("w1c_clear",   reg_val1[5], 32'h5555_5555);
        idle();

        // Back-to-back reads, one result per cycle in order; rd_data holds after
        do_read(12'h004, 32'h0123_4567);
        step();
        do_read(12'h008, 32'h2222_A5A5);
        step();
        do_read(12'h00C, 32'h3333_3333);
        step();
        idle();
        repeat (3) step();
        chk("hold_rd1",    rd_data1, 32'h3333_3333);
        chk("hold_rd2",    rd_data2, 32'h3333_3333);
        chk("hold_vld1",   32'(rd_valid1), 32'h0);
        chk("hold_vld2",   32'(rd_valid2), 32'h0);

`ifdef MEM_REGFILE_MC_DECODE_ERR_EN
        do_read(12'h040, 32'hDEC0_DEE0);
        step();
        chk("dec_no_rdstb", 32'(rd_stb1), 32'h0);
        chk("dec_err1",     32'(err_cnt1), 32'h1);
        do_write(12'h048, 4'b1111, 32'hFFFF_FFFF);
        step();
        chk("dec_wr_drop",  reg_val1[2], 32'h2222_A5A5);
        chk("dec_no_wrstb", 32'(wr_stb1), 32'h0);
        chk("dec_err1_2",   32'(err_cnt1), 32'h2);
        chk("dec_err2_2",   32'(err_cnt2), 32'h2);
        idle();
`else
        do_read(12'h048, 32'h2222_A5A5);
        step();
        chk("alias_rdstb",  32'(rd_stb1), 32'h0004);
        chk("alias_err",    32'(err_cnt1), 32'h0);
        idle();
`endif
        repeat (3) step();

        // Reset mid-burst with a write in flight
        do_read(12'h004, 32'h0123_4567);
        step();
        do_read(12'h008, 32'h2222_A5A5);
        step();
        do_write(12'h00C, 4'b1111, 32'h0);
        #2;
        resetn = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk("mid_rst_vld1",  32'(rd_valid1), 32'h0);
        chk("mid_rst_vld2",  32'(rd_valid2), 32'h0);
        chk("mid_rst_dat1",  rd_data1, 32'h0);
        chk("mid_rst_dat2",  rd_data2, 32'h0);
        chk("mid_rst_reg2",  reg_val1[2], 32'h2222_2222);
        chk("mid_rst_reg5",  reg_val1[5], 32'h5555_5555);
        chk("mid_rst_rdstb", 32'(rd_stb1), 32'h0);
        en = 1'b0;
        we = '0;
        repeat (2) step();
        chk("mid_rst_reg3",  reg_val1[3], 32'h3333_3333);
        resetn = 1'b1;
        repeat (4) idle();

        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
